// File: rtl/alu_pkg.sv
// alu_pkg: instruction IDs, MIPS opcode/funct encodings and sequencer state types.
package alu_pkg;
  localparam logic [31:0] ID_NONE  = 32'd0;
  localparam logic [31:0] ID_ADD   = 32'd1;
  localparam logic [31:0] ID_SUB   = 32'd2;
  localparam logic [31:0] ID_ADDU  = 32'd3;
  localparam logic [31:0] ID_SUBU  = 32'd4;
  localparam logic [31:0] ID_ADDI  = 32'd5;
  localparam logic [31:0] ID_ADDIU = 32'd6;
  localparam logic [31:0] ID_AND   = 32'd7;
  localparam logic [31:0] ID_OR    = 32'd8;
  localparam logic [31:0] ID_ANDI  = 32'd9;
  localparam logic [31:0] ID_ORI   = 32'd10;
  localparam logic [31:0] ID_SLL   = 32'd11;
  localparam logic [31:0] ID_SRL   = 32'd12;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  typedef enum logic [1:0] {IDLE, FETCH, DECODE, EXEC} state_t;
  typedef enum logic [1:0] {OPB_REG, OPB_SEXT, OPB_ZEXT, OPB_SHAMT} opb_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational MIPS word decoder producing instr_ID, register indices and operand-b source.
module instr_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] instr_id,
  output logic [4:0]  dest,
  output logic [4:0]  a_idx,
  output logic [4:0]  b_idx,
  output opb_t        b_sel,
  output logic [31:0] imm
);
  always_comb begin
    instr_id = ID_NONE;
    dest = instr[15:11];
    a_idx = instr[25:21];
    b_idx = instr[20:16];
    b_sel = OPB_REG;
    if (instr[31:26] == OP_RTYPE) begin
      case (instr[5:0])
        FN_ADD:  instr_id = ID_ADD;
        FN_SUB:  instr_id = ID_SUB;
        FN_ADDU: instr_id = ID_ADDU;
        FN_SUBU: instr_id = ID_SUBU;
        FN_AND:  instr_id = ID_AND;
        FN_OR:   instr_id = ID_OR;
        FN_SLL: begin
          instr_id = ID_SLL;
          a_idx = instr[20:16];
          b_sel = OPB_SHAMT;
        end
        FN_SRL: begin
          instr_id = ID_SRL;
          a_idx = instr[20:16];
          b_sel = OPB_SHAMT;
        end
        default: instr_id = ID_NONE;
      endcase
    end else begin
      dest = instr[20:16];
      case (instr[31:26])
        OP_ADDI: begin
          instr_id = ID_ADDI;
          b_sel = OPB_SEXT;
        end
        OP_ADDIU: begin
          instr_id = ID_ADDIU;
          b_sel = OPB_SEXT;
        end
        OP_ANDI: begin
          instr_id = ID_ANDI;
          b_sel = OPB_ZEXT;
        end
        OP_ORI: begin
          instr_id = ID_ORI;
          b_sel = OPB_ZEXT;
        end
        default: instr_id = ID_NONE;
      endcase
    end
  end
  assign imm = b_sel == OPB_SHAMT ? {27'b0, instr[10:6]}
             : b_sel == OPB_ZEXT  ? {16'b0, instr[15:0]}
             : {{16{instr[15]}}, instr[15:0]};
endmodule

// File: rtl/instr_issue.sv
// instr_issue: fetch/decode/issue sequencer owning the PC and 32x32 register file that feeds alu_top.
module instr_issue
  import alu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_ID,
  output logic [31:0] rs,
  output logic [31:0] rt,
  output logic [31:0] initial_pc,
  input  logic [31:0] alu_rd,
  input  logic [31:0] alu_pc,
  output logic        retire,
  output logic        illegal,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);
  state_t state, state_nx;
  logic [31:0] pc, ir;
  logic [31:0] regs [32];
  logic [4:0] dest;
  logic [31:0] d_id, d_imm;
  logic [4:0] d_dest, d_a, d_b;
  opb_t d_bsel;
  instr_decode u_dec (
    .instr(ir),
    .instr_id(d_id),
    .dest(d_dest),
    .a_idx(d_a),
    .b_idx(d_b),
    .b_sel(d_bsel),
    .imm(d_imm)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = run ? FETCH : IDLE;
      FETCH:   state_nx = imem_ack ? DECODE : FETCH;
      DECODE:  state_nx = EXEC;
      default: state_nx = run ? FETCH : IDLE;
    endcase
  end
  assign imem_req = state == FETCH;
  assign imem_addr = pc;
  assign dbg_rdata = regs[dbg_raddr];
  // regs[0] is cleared on reset and never written, so R0 reads as zero everywhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      instr_ID <= ID_NONE;
      rs <= '0;
      rt <= '0;
      initial_pc <= RESET_PC;
      dest <= '0;
      retire <= 1'b0;
      illegal <= 1'b0;
      regs <= '{default: '0};
    end else begin
      state <= state_nx;
      retire <= 1'b0;
      illegal <= 1'b0;
      if (state == FETCH && imem_ack) ir <= imem_rdata;
      if (state == DECODE) begin
        instr_ID <= d_id;
        rs <= regs[d_a];
        rt <= d_bsel == OPB_REG ? regs[d_b] : d_imm;
        initial_pc <= pc;
        dest <= d_dest;
      end
      if (state == EXEC) begin
        if (instr_ID != ID_NONE) begin
          if (dest != 5'd0) regs[dest] <= alu_rd;
          pc <= alu_pc;
          retire <= 1'b1;
        end else begin
          pc <= pc + 32'd4;
          illegal <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: directed self-checking bench for the instr_issue sequencer.
`timescale 1ns/1ps
module tb_instr_issue;
  localparam logic [31:0] RPC = 32'h0000_0100;
  logic clk = 0, rst = 1, run = 0, imem_ack = 0, retire, illegal, imem_req;
  logic [31:0] imem_addr, imem_rdata = 0, instr_ID, rs, rt, initial_pc, alu_rd = 0, alu_pc = 0, dbg_rdata;
  logic [4:0] dbg_raddr = 0;
  int checks = 0, errors = 0;
  instr_issue #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_ID(instr_ID), .rs(rs), .rt(rt),
    .initial_pc(initial_pc), .alu_rd(alu_rd), .alu_pc(alu_pc), .retire(retire),
    .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    dbg_raddr = a;
    #1;
    v = dbg_rdata;
  endtask

  // Waits for FETCH, acks with w, and returns one step into EXEC.
  task automatic issue(input logic [31:0] w, input bit drop_run);
    int n = 0;
    while (!imem_req && n < 20) begin
      step;
      n++;
    end
    if (!imem_req) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout imem_req=%b expected 1", imem_req);
    end
    imem_rdata = w;
    imem_ack = 1;
    step;
    imem_ack = 0;
    if (drop_run) run = 0;
    step;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    repeat (2) step;
    rst = 0;
    checks++; if (imem_req !== 0 || imem_addr !== RPC || initial_pc !== RPC) begin errors++; $display("FAIL reset_idle req=%b addr=%h ipc=%h expected 0/%h/%h", imem_req, imem_addr, initial_pc, RPC, RPC); end
    run = 1;
    step;
    checks++; if (imem_req !== 1) begin errors++; $display("FAIL fetch_req got %b expected 1", imem_req); end
    #2 rst = 1;
    #1;
    checks++; if (imem_req !== 0 || imem_addr !== RPC) begin errors++; $display("FAIL reset_async req=%b addr=%h expected 0/%h", imem_req, imem_addr, RPC); end
    checks++; if ({instr_ID, rs, rt} !== 96'd0 || retire !== 0 || illegal !== 0 || initial_pc !== RPC) begin errors++; $display("FAIL reset_outs id=%h rs=%h rt=%h ret=%b ill=%b ipc=%h expected zeros", instr_ID, rs, rt, retire, illegal, initial_pc); end
    for (int i = 0; i < 32; i++) begin
      rd_reg(i[4:0], v);
      checks++; if (v !== 0) begin errors++; $display("FAIL reset_reg%0d got %h expected 0", i, v); end
    end
    run = 0;
    step;
    rst = 0;
  endtask

  task automatic test_ack_ignored;
    logic [31:0] v;
    imem_rdata = 32'h2001_0001;
    imem_ack = 1;
    alu_rd = 32'h1234;
    repeat (3) step;
    imem_ack = 0;
    rd_reg(1, v);
    checks++; if (imem_req !== 0 || retire !== 0 || v !== 0 || imem_addr !== RPC) begin errors++; $display("FAIL ack_idle req=%b ret=%b r1=%h addr=%h expected 0/0/0/%h", imem_req, retire, v, imem_addr, RPC); end
  endtask

  task automatic test_addi;
    logic [31:0] v;
    run = 1;
    alu_rd = 32'hFFFF_FFFB;
    alu_pc = 32'd4;
    issue(32'h2001_FFFB, 0);
    checks++; if (instr_ID !== 5 || rs !== 0 || rt !== 32'hFFFF_FFFB || initial_pc !== RPC) begin errors++; $display("FAIL addi_issue id=%0d rs=%h rt=%h ipc=%h expected 5/0/fffffffb/%h", instr_ID, rs, rt, initial_pc, RPC); end
    step;
    rd_reg(1, v);
    checks++; if (retire !== 1 || illegal !== 0 || v !== 32'hFFFF_FFFB || imem_addr !== 4) begin errors++; $display("FAIL addi_retire ret=%b ill=%b r1=%h addr=%h expected 1/0/fffffffb/4", retire, illegal, v, imem_addr); end
  endtask

  task automatic test_raw;
    logic [31:0] v;
    alu_rd = 3; alu_pc = 8;
    issue(32'h2001_0003, 0);
    step;
    alu_rd = 4; alu_pc = 12;
    issue(32'h2002_0004, 0);
    step;
    alu_rd = 7; alu_pc = 16;
    issue(32'h0022_1820, 0);
    checks++; if (instr_ID !== 1 || rs !== 3 || rt !== 4 || initial_pc !== 12) begin errors++; $display("FAIL add_issue id=%0d rs=%h rt=%h ipc=%h expected 1/3/4/c", instr_ID, rs, rt, initial_pc); end
    step;
    rd_reg(3, v);
    checks++; if (retire !== 1 || v !== 7) begin errors++; $display("FAIL add_retire ret=%b r3=%h expected 1/7", retire, v); end
    step;
    checks++; if (retire !== 0) begin errors++; $display("FAIL retire_pulse got %b expected 0", retire); end
  endtask

  task automatic test_shift_imm;
    logic [31:0] v;
    alu_rd = 32'h30; alu_pc = 20;
    issue(32'h0001_1100, 0);
    checks++; if (instr_ID !== 11 || rs !== 3 || rt !== 4) begin errors++; $display("FAIL sll_issue id=%0d rs=%h rt=%h expected 11/3/4", instr_ID, rs, rt); end
    step;
    rd_reg(2, v);
    checks++; if (v !== 32'h30) begin errors++; $display("FAIL sll_write r2=%h expected 30", v); end
    alu_rd = 32'hBAD; alu_pc = 24;
    issue(32'h3400_0005, 0);
    checks++; if (instr_ID !== 10 || rs !== 0 || rt !== 5) begin errors++; $display("FAIL ori_issue id=%0d rs=%h rt=%h expected 10/0/5", instr_ID, rs, rt); end
    step;
    rd_reg(0, v);
    checks++; if (retire !== 1 || v !== 0) begin errors++; $display("FAIL ori_r0 ret=%b r0=%h expected 1/0", retire, v); end
    alu_rd = 0; alu_pc = 28;
    issue(32'h3064_8000, 0);
    checks++; if (instr_ID !== 9 || rs !== 7 || rt !== 32'h0000_8000) begin errors++; $display("FAIL andi_zext id=%0d rs=%h rt=%h expected 9/7/8000", instr_ID, rs, rt); end
    step;
  endtask

  task automatic test_illegal;
    logic [31:0] v1, v3;
    alu_rd = 32'h55; alu_pc = 32'hDEAD_0000;
    issue(32'hFC00_0000, 0);
    checks++; if (instr_ID !== 0) begin errors++; $display("FAIL illegal_id got %0d expected 0", instr_ID); end
    step;
    rd_reg(1, v1);
    rd_reg(3, v3);
    checks++; if (illegal !== 1 || retire !== 0 || imem_addr !== 32 || v1 !== 3 || v3 !== 7) begin errors++; $display("FAIL illegal_exec ill=%b ret=%b addr=%h r1=%h r3=%h expected 1/0/20/3/7", illegal, retire, imem_addr, v1, v3); end
  endtask

  task automatic test_handshake;
    logic [31:0] v;
    for (int i = 0; i < 5; i++) begin
      checks++; if (imem_req !== 1 || imem_addr !== 32) begin errors++; $display("FAIL hold_%0d req=%b addr=%h expected 1/20", i, imem_req, imem_addr); end
      step;
    end
    alu_rd = 14; alu_pc = 36;
    issue(32'h0063_2820, 0);
    checks++; if (instr_ID !== 1 || rs !== 7 || rt !== 7 || initial_pc !== 32) begin errors++; $display("FAIL hs_issue id=%0d rs=%h rt=%h ipc=%h expected 1/7/7/20", instr_ID, rs, rt, initial_pc); end
    step;
    rd_reg(5, v);
    checks++; if (v !== 14) begin errors++; $display("FAIL hs_write r5=%h expected e", v); end
  endtask

  task automatic test_run_drop;
    logic [31:0] v;
    alu_rd = 1; alu_pc = 40;
    issue(32'h2006_0001, 1);
    checks++; if (instr_ID !== 5 || rt !== 1) begin errors++; $display("FAIL drop_issue id=%0d rt=%h expected 5/1", instr_ID, rt); end
    step;
    rd_reg(6, v);
    checks++; if (retire !== 1 || imem_req !== 0 || v !== 1 || imem_addr !== 40) begin errors++; $display("FAIL drop_retire ret=%b req=%b r6=%h addr=%h expected 1/0/1/28", retire, imem_req, v, imem_addr); end
    step;
    checks++; if (imem_req !== 0 || retire !== 0) begin errors++; $display("FAIL drop_idle req=%b ret=%b expected 0/0", imem_req, retire); end
  endtask

  initial begin
    test_reset;
    test_ack_ignored;
    test_addi;
    test_raw;
    test_shift_imm;
    test_illegal;
    test_handshake;
    test_run_drop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_issue.md
# instr_issue

- Multi-cycle fetch/decode/issue sequencer that drives the operand side of `alu_top`.
- Fetches a 32-bit MIPS word over a req/ack instruction-memory handshake, decodes it to the team's numeric `instr_ID`, reads the 32×32 register file it owns, and presents `instr_ID`/`rs`/`rt`/`initial_pc` to the ALU.
- Retires by writing the ALU's `rd` and `pc` back into the register file and the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: level; allows a new fetch to start.
- `imem_req` out 1: fetch request, held until ack.
- `imem_addr` out 32: fetch address, equals PC, stable while `imem_req`.
- `imem_ack` in 1: `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `instr_ID` out 32: operation code to ALU; 0 = none/illegal.
- `rs` out 32: ALU operand a.
- `rt` out 32: ALU operand b.
- `initial_pc` out 32: PC of the issued instruction.
- `alu_rd` in 32: ALU result.
- `alu_pc` in 32: ALU next PC.
- `retire` out 1: one-cycle pulse per completed legal instruction.
- `illegal` out 1: one-cycle pulse per undecodable instruction.
- `dbg_raddr` in 5: debug register select.
- `dbg_rdata` out 32: combinational register-file read; R0 reads 0.

## Operation
- **instr_ID map:**

  | Value | Op | Value | Op |
  |---|---|---|---|
  | 1 | add (funct 0x20) | 7 | and (0x24) |
  | 2 | sub (0x22) | 8 | or (0x25) |
  | 3 | addu (0x21) | 9 | andi (0x0C) |
  | 4 | subu (0x23) | 10 | ori (0x0D) |
  | 5 | addi (opcode 0x08) | 11 | sll (funct 0x00) |
  | 6 | addiu (0x09) | 12 | srl (0x02) |

  R-type ops have opcode 0. Anything else is illegal.
- **Operand rules:**
  - R-type arithmetic/logic: `rs`=R[25:21], `rt`=R[20:16], dest [15:11].
  - addi/addiu: `rt` = sign-extended imm[15:0].
  - andi/ori: `rt` = zero-extended imm.
  - I-type dest is [20:16].
  - sll/srl: `rs`=R[20:16], `rt`={27'b0, shamt[10:6]}.
- **Register file:**
  - R0 is hardwired 0; writes to R0 are discarded.
  - One write port, written only at EXEC exit.
- **FSM states:** IDLE, FETCH, DECODE, EXEC.
  - IDLE → FETCH when `run`=1.
  - FETCH: `imem_req`=1. → DECODE on the edge where `imem_ack`=1; instruction latched.
  - DECODE: decode, register read. ALU outputs registered on the exit edge. → EXEC.
  - EXEC, legal instruction: on the exit edge, dest ← `alu_rd` and PC ← `alu_pc`; `retire` pulses the next cycle.
  - EXEC, illegal instruction: no register write; PC ← PC+4 (wraps mod 2^32); `illegal` pulses the next cycle.
  - EXEC → FETCH if `run`, else IDLE.
- **Boundaries:**
  - `run` dropping mid-instruction: the instruction completes, then IDLE.
  - `imem_ack` outside FETCH is ignored.
  - `rst` mid-operation: all state returns to reset values immediately; `imem_req` drops the same cycle.

## Timing
- **Reset values:**
  - `imem_req`=0, `instr_ID`=0, `rs`=0, `rt`=0, `retire`=0, `illegal`=0.
  - `imem_addr` = `initial_pc` = `RESET_PC`.
  - All registers 0; FSM in IDLE.
- **Latency:** minimum 3 cycles per instruction (FETCH with same-cycle ack, DECODE, EXEC).
- **ALU outputs:** `instr_ID`/`rs`/`rt`/`initial_pc` are stable from DECODE exit through EXEC.
- **ALU inputs:** `alu_rd`/`alu_pc` are sampled only at the EXEC exit edge; the ALU is purely combinational within that cycle.
- **Read-after-write:** a write in EXEC is visible to the next DECODE. No bypass is needed.

## Structure
- **Package `alu_pkg`:**
  - `instr_ID` constants 0–12.
  - Opcode and funct constants.
  - FSM state enum.
- **Sub-module `instr_decode`** (combinational), invoked from DECODE:
  - Input: instruction word.
  - Outputs: `instr_ID`, dest index, operand-b select, extension type.

## Test plan
- **Reset:** `rst` pulse mid-FETCH → `imem_req`=0, `imem_addr`=`RESET_PC`, all outputs 0, `dbg_rdata`=0 for every index.
- **addi:** `addi $1,$0,-5` (0x2001FFFB) with `alu_rd`=0xFFFFFFFB, `alu_pc`=4 → `instr_ID`=5, `rt`=0xFFFFFFFB. After retire: R1=0xFFFFFFFB, `imem_addr`=4.
- **Register read of written result:** with R1=3 and R2=4, issue `add $3,$1,$2` (0x00221820) → `instr_ID`=1, `rs`=3, `rt`=4. With `alu_rd`=7, R3=7.
- **Shift:** `sll $2,$1,4` (0x00011100) → `instr_ID`=11, `rs`=R1, `rt`=4.
- **Illegal / R0 writes:**
  - Word 0xFC000000 → `illegal` pulses, no register change, PC advances by 4.
  - `ori $0,$0,5` → R0 still reads 0.
- **Handshake / run:**
  - `imem_ack` delayed 5 cycles → `imem_req` and `imem_addr` held stable for those 5 cycles.
  - `run` cleared during DECODE → instruction retires, then FSM in IDLE with `imem_req`=0.
